// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the 16-bit UART transmit/receive controllers.
// Holds the byte/word widths, the default inter-byte gap and the RX state and word types.
package uart_ctrl_pkg;

  localparam int unsigned BYTE_W           = 8;
  localparam int unsigned WORD_W           = 16;
  localparam int unsigned INTER_BYTE_DELAY = 1000000;

  typedef enum logic [1:0] {
    RX_IDLE        = 2'd0,
    RX_WAIT_BYTE_1 = 2'd1,
    RX_WORD_READY  = 2'd2
  } rx_state_e;

  // Assembled word: high byte arrives second on the line, low byte first.
  typedef struct packed {
    logic [BYTE_W-1:0] high;
    logic [BYTE_W-1:0] low;
  } rx_word_t;

endpackage

// File: rtl/hold_timer.sv
// Up-counter with synchronous clear and enable.
// Flags the terminal count combinationally when the count reaches LIMIT-1.
module hold_timer
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = 2 * INTER_BYTE_DELAY,
  parameter int unsigned WIDTH = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal_count_c
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  assign terminal_count_c = (count == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/uart_rx_ctrl16.sv
// Receive-side controller: pairs two consecutive bytes (low first) into a 16-bit word
// with a valid/ack handshake, and flags inter-byte timeout, overrun and line errors.
module uart_rx_ctrl16
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned INTER_BYTE_TIMEOUT = 2 * INTER_BYTE_DELAY,
  parameter int unsigned TIMER_WIDTH        = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_ready,
  input  logic              rx_error,
  input  logic              data_ack,
  output logic [WORD_W-1:0] data_out16,
  output logic              data_valid,
  output logic              busy,
  output logic              timeout_err,
  output logic              overrun_err,
  output logic              line_err
);

  localparam logic [1:0] IDLE        = RX_IDLE;
  localparam logic [1:0] WAIT_BYTE_1 = RX_WAIT_BYTE_1;
  localparam logic [1:0] WORD_READY  = RX_WORD_READY;

  logic [1:0]        state, state_n;
  logic [BYTE_W-1:0] byte0, byte0_n;
  rx_word_t          word_q, word_n;
  logic              valid_n, busy_n, timeout_n, overrun_n, line_n;
  logic              timer_en_c, timer_clear_c, timer_done_c;
  logic              byte_ok_c;

  // Timer runs only while waiting for the high byte and sits at 0 otherwise.
  assign timer_en_c    = (state == WAIT_BYTE_1);
  assign timer_clear_c = ~timer_en_c;
  assign byte_ok_c     = rx_ready & ~rx_error;

  hold_timer #(
    .LIMIT (INTER_BYTE_TIMEOUT),
    .WIDTH (TIMER_WIDTH)
  ) u_hold_timer (
    .clock            (clock),
    .reset            (reset),
    .clear            (timer_clear_c),
    .enable           (timer_en_c),
    .terminal_count_c (timer_done_c)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      byte0       <= '0;
      word_q      <= '0;
      data_valid  <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
      line_err    <= 1'b0;
    end else begin
      state       <= state_n;
      byte0       <= byte0_n;
      word_q      <= word_n;
      data_valid  <= valid_n;
      busy        <= busy_n;
      timeout_err <= timeout_n;
      overrun_err <= overrun_n;
      line_err    <= line_n;
    end
  end

  always_comb begin
    state_n   = state;
    byte0_n   = byte0;
    word_n    = word_q;
    valid_n   = data_valid;
    timeout_n = 1'b0;
    overrun_n = 1'b0;
    line_n    = 1'b0;

    case (state)
      IDLE: begin
        if (rx_error) begin
          line_n = 1'b1;
        end else if (rx_ready) begin
          byte0_n = rx_data;
          state_n = WAIT_BYTE_1;
        end
      end

      // A byte arriving on the timeout cycle still completes the word.
      WAIT_BYTE_1: begin
        if (rx_error) begin
          line_n  = 1'b1;
          byte0_n = '0;
          state_n = IDLE;
        end else if (rx_ready) begin
          word_n.high = rx_data;
          word_n.low  = byte0;
          valid_n     = 1'b1;
          state_n     = WORD_READY;
        end else if (timer_done_c) begin
          timeout_n = 1'b1;
          byte0_n   = '0;
          state_n   = IDLE;
        end
      end

      WORD_READY: begin
        line_n = rx_error;
        if (data_ack) begin
          valid_n = 1'b0;
          state_n = IDLE;
          if (byte_ok_c) begin
            byte0_n = rx_data;
            state_n = WAIT_BYTE_1;
          end
        end else if (byte_ok_c) begin
          overrun_n = 1'b1;
        end
      end

      default: begin
        valid_n = 1'b0;
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  assign data_out16 = word_q;

endmodule

// File: tb/tb_uart_rx_ctrl16.sv
// Bench for uart_rx_ctrl16: directed scenarios followed by randomized traffic, all
// checked every cycle against an event-level model of the word-assembly rules.
module tb_uart_rx_ctrl16;

  localparam int unsigned T = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready = 1'b0;
  logic        rx_error = 1'b0;
  logic        data_ack = 1'b0;
  logic [15:0] data_out16;
  logic        data_valid, busy, timeout_err, overrun_err, line_err;

  int checks   = 0;
  int failures = 0;

  // Model: a held low byte with its waiting age, and a held complete word.
  bit          m_low_held, m_word_held;
  logic [7:0]  m_low;
  int          m_waited;
  logic [15:0] m_word;
  bit          m_to, m_ov, m_le;

  always #5 clock = ~clock;

  uart_rx_ctrl16 #(
    .INTER_BYTE_TIMEOUT (T),
    .TIMER_WIDTH        (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .rx_error    (rx_error),
    .data_ack    (data_ack),
    .data_out16  (data_out16),
    .data_valid  (data_valid),
    .busy        (busy),
    .timeout_err (timeout_err),
    .overrun_err (overrun_err),
    .line_err    (line_err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_low_held  = 1'b0;
    m_word_held = 1'b0;
    m_low       = 8'h00;
    m_waited    = 0;
    m_word      = 16'h0000;
    m_to = 1'b0; m_ov = 1'b0; m_le = 1'b0;
  endtask

  task automatic model_step(input bit rdy, input logic [7:0] d, input bit err, input bit ack);
    m_to = 1'b0; m_ov = 1'b0; m_le = 1'b0;
    if (m_word_held) begin
      if (err) m_le = 1'b1;
      if (ack) begin
        m_word_held = 1'b0;
        if (rdy && !err) begin
          m_low_held = 1'b1; m_low = d; m_waited = 0;
        end
      end else if (rdy && !err) begin
        m_ov = 1'b1;
      end
    end else if (m_low_held) begin
      if (err) begin
        m_le = 1'b1; m_low_held = 1'b0;
      end else if (rdy) begin
        m_word = {d, m_low}; m_word_held = 1'b1; m_low_held = 1'b0;
      end else begin
        m_waited++;
        if (m_waited == int'(T)) begin
          m_to = 1'b1; m_low_held = 1'b0;
        end
      end
    end else begin
      if (err) m_le = 1'b1;
      else if (rdy) begin
        m_low_held = 1'b1; m_low = d; m_waited = 0;
      end
    end
  endtask

  task automatic check_model();
    chk("data_out16",  data_out16,       m_word);
    chk("data_valid",  16'(data_valid),  16'(m_word_held));
    chk("busy",        16'(busy),        16'(m_low_held || m_word_held));
    chk("timeout_err", 16'(timeout_err), 16'(m_to));
    chk("overrun_err", 16'(overrun_err), 16'(m_ov));
    chk("line_err",    16'(line_err),    16'(m_le));
  endtask

  task automatic cycle(input bit rdy, input logic [7:0] d, input bit err, input bit ack);
    rx_ready = rdy; rx_data = d; rx_error = err; data_ack = ack;
    @(posedge clock);
    model_step(rdy, d, err, ack);
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rx_ready = 1'b0; rx_data = 8'h00; rx_error = 1'b0; data_ack = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    model_reset();
    #1;
    check_model();
    chk("rst_all_zero", {data_out16[15:6], data_valid, busy, timeout_err, overrun_err, line_err, 1'b0}, 16'h0000);
    reset = 1'b0;
  endtask

  initial begin
    int pct;
    bit rdy, err, ack;
    logic [7:0] d;

    model_reset();
    do_reset();

    // 1: basic pair, hold then ack
    cycle(1'b1, 8'h34, 1'b0, 1'b0);
    idle(4);
    cycle(1'b1, 8'h12, 1'b0, 1'b0);
    chk("t1_word", data_out16, 16'h1234);
    chk("t1_valid", 16'(data_valid), 16'h0001);
    idle(2);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t1_ack_valid", 16'(data_valid), 16'h0000);
    chk("t1_ack_busy", 16'(busy), 16'h0000);

    // 2: timeout then a fresh word
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    idle(int'(T) - 1);
    chk("t2_no_early_timeout", 16'(timeout_err), 16'h0000);
    idle(1);
    chk("t2_timeout", 16'(timeout_err), 16'h0001);
    chk("t2_idle_busy", 16'(busy), 16'h0000);
    idle(1);
    chk("t2_pulse_once", 16'(timeout_err), 16'h0000);
    cycle(1'b1, 8'h01, 1'b0, 1'b0);
    cycle(1'b1, 8'h02, 1'b0, 1'b0);
    chk("t2_word", data_out16, 16'h0201);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // 3: second byte on the timeout cycle wins
    cycle(1'b1, 8'h78, 1'b0, 1'b0);
    idle(int'(T) - 1);
    cycle(1'b1, 8'h56, 1'b0, 1'b0);
    chk("t3_word", data_out16, 16'h5678);
    chk("t3_no_timeout", 16'(timeout_err), 16'h0000);
    idle(1);
    chk("t3_still_no_timeout", 16'(timeout_err), 16'h0000);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // 4: overrun, then ack coincident with a new low byte
    cycle(1'b1, 8'hEF, 1'b0, 1'b0);
    cycle(1'b1, 8'hBE, 1'b0, 1'b0);
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    chk("t4_overrun", 16'(overrun_err), 16'h0001);
    chk("t4_word_kept", data_out16, 16'hBEEF);
    idle(1);
    cycle(1'b1, 8'h22, 1'b0, 1'b1);
    chk("t4_no_overrun", 16'(overrun_err), 16'h0000);
    chk("t4_busy", 16'(busy), 16'h0001);
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    chk("t4_word", data_out16, 16'h3322);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // 5: line error discards partial word
    cycle(1'b1, 8'h10, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t5_line_err", 16'(line_err), 16'h0001);
    chk("t5_idle", 16'(busy), 16'h0000);
    cycle(1'b1, 8'h01, 1'b0, 1'b0);
    cycle(1'b1, 8'h02, 1'b0, 1'b0);
    chk("t5_word", data_out16, 16'h0201);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // 6: reset mid-word and with a word pending
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    do_reset();
    cycle(1'b1, 8'h66, 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    do_reset();
    cycle(1'b1, 8'hCD, 1'b0, 1'b0);
    cycle(1'b1, 8'hAB, 1'b0, 1'b0);
    chk("t6_word", data_out16, 16'hABCD);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Randomized traffic; sparse segments provoke timeouts
    for (int i = 0; i < 3000; i++) begin
      case ((i / 200) % 3)
        0:       pct = 2;
        1:       pct = 15;
        default: pct = 50;
      endcase
      rdy = ($urandom_range(0, 99) < pct);
      err = ($urandom_range(0, 99) < 3);
      ack = ($urandom_range(0, 99) < 25);
      d   = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 999) == 0) do_reset();
      else cycle(rdy, d, err, ack);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
